// File: rtl/matmul_engine_arbiter.sv
// Round-robin arbiter and sequencer sharing one serial 3x3 matrix-multiply
// engine among NUM_REQ requesters: grant, start pulse, wait for done or
// timeout, then hold a tagged response until the consumer accepts it.
module matmul_engine_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   eng_sel,
    output logic               eng_start,
    input  logic               eng_done,
    output logic               rsp_valid,
    output logic [SEL_W-1:0]   rsp_id,
    output logic               rsp_err,
    input  logic               rsp_ready,
    output logic               busy,
    output logic [15:0]        job_count
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick;
    logic             pick_valid;
    logic [SEL_W-1:0] cand;
    logic             armed;
    logic [7:0]       wait_cnt;
    logic             done_ok;
    logic             timed_out;

    // A stale done left over from the previous job only counts once it has been seen low.
    assign done_ok   = armed && eng_done;
    assign timed_out = (wait_cnt == 8'(TIMEOUT - 1));

    assign eng_start = (state == START);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Round-robin search from last+1 upward with wrap; descending loop so the nearest requester wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = SEL_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // State register; an asynchronous reset drops any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: one job at a time, released only on the response handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (done_ok || timed_out) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant, tag, arm/timeout tracking, round-robin pointer and completed-job counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            eng_sel   <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            armed     <= 1'b0;
            wait_cnt  <= '0;
            job_count <= '0;
            last      <= SEL_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        eng_sel <= pick;
                        rsp_id  <= pick;
                        rsp_err <= 1'b0;
                    end
                end
                START: begin
                    armed    <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (!eng_done) begin
                        armed <= 1'b1;
                    end
                    if (!done_ok && timed_out) begin
                        rsp_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        last      <= rsp_id;
                        job_count <= job_count + 16'd1;
                        gnt       <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_engine_arbiter.sv
// Self-checking bench for matmul_engine_arbiter: a job-level reference model
// with timing arithmetic, a per-cycle compare process, a behavioural engine,
// and directed scenarios pinned by hand-computed literals.
module tb_matmul_engine_arbiter;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 64;

    logic               clk;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   eng_sel;
    logic               eng_start;
    logic               eng_done;
    logic               rsp_valid;
    logic [SEL_W-1:0]   rsp_id;
    logic               rsp_err;
    logic               rsp_ready;
    logic               busy;
    logic [15:0]        job_count;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_active = 0;
    int m_resp = 0;
    int m_err = 0;
    int m_id = 0;
    int m_sel = 0;
    int m_last = NUM_REQ - 1;
    int m_count = 0;
    int m_armed = 0;
    int m_start_now = 0;
    int m_grant_edge = 0;
    int cyc = 0;

    // engine behaviour knobs
    int done_delay = 3;
    int stale_hold = 0;

    // monitor records
    int gq[$];
    int nc = 0;
    int start_nc = 0;
    int last_lat = 0;
    int last_id = 0;
    int last_err = 0;
    int vcount = 0;

    matmul_engine_arbiter #(
        .NUM_REQ(NUM_REQ),
        .SEL_W  (SEL_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .gnt      (gnt),
        .eng_sel  (eng_sel),
        .eng_start(eng_start),
        .eng_done (eng_done),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_err  (rsp_err),
        .rsp_ready(rsp_ready),
        .busy     (busy),
        .job_count(job_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic rdy);
        req       = r;
        rsp_ready = rdy;
    endtask

    function automatic int rrPick(input logic [NUM_REQ-1:0] r, input int lastIdx);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(lastIdx + k) % NUM_REQ]) return (lastIdx + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic waitStarts(input int n, input int budget, input string name);
        int k = 0;
        while (gq.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput(name, 32'(gq.size() >= n), 32'd1);
    endtask

    task automatic waitValid(input int budget, input string name);
        int k = 0;
        while (!rsp_valid && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput(name, 32'(rsp_valid), 32'd1);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (busy && k < budget);
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // Reference model: one job at a time, response timing derived from grant edge and done samples.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_active = 0; m_resp = 0; m_err = 0; m_id = 0; m_sel = 0;
                m_last = NUM_REQ - 1; m_count = 0; m_armed = 0; m_start_now = 0;
                cyc = 0;
            end else begin
                int waitk;
                cyc++;
                m_start_now = 0;
                if (!m_active) begin
                    if (req != 0) begin
                        m_id = rrPick(req, m_last);
                        m_sel = m_id;
                        m_active = 1; m_resp = 0; m_err = 0; m_armed = 0;
                        m_grant_edge = cyc;
                        m_start_now = 1;
                    end
                end else if (!m_resp) begin
                    waitk = cyc - m_grant_edge - 1;
                    if (waitk >= 1) begin
                        if (m_armed && eng_done) begin
                            m_resp = 1; m_err = 0;
                        end else if (waitk == TIMEOUT) begin
                            m_resp = 1; m_err = 1;
                        end
                        if (!eng_done) m_armed = 1;
                    end
                end else if (rsp_ready) begin
                    m_count = (m_count + 1) & 16'hFFFF;
                    m_last = m_id;
                    m_active = 0; m_resp = 0;
                end
            end
        end
    end

    // Behavioural engine: done is a level that rises done_delay cycles after start, stale level optionally held.
    initial begin
        int e_cnt;
        int e_run;
        e_cnt = 0;
        e_run = 0;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                e_cnt = 0;
                e_run = 1;
                if (stale_hold == 0) eng_done = 1'b0;
            end else if (e_run != 0) begin
                e_cnt++;
                if (e_cnt == stale_hold) eng_done = 1'b0;
                if (done_delay != 0 && e_cnt == done_delay) begin
                    eng_done = 1'b1;
                    e_run = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model plus grant/latency bookkeeping.
    initial begin
        forever begin
            @(negedge clk);
            nc++;
            if (eng_start) begin
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gq.push_back(i);
                start_nc = nc;
                vcount = 0;
            end
            if (rsp_valid) begin
                if (vcount == 0) last_lat = nc - start_nc;
                vcount++;
                last_id = int'(rsp_id);
                last_err = int'(rsp_err);
            end
            checkOutput("gnt", 32'(gnt), m_active != 0 ? (32'd1 << m_id) : 32'd0);
            checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            checkOutput("eng_start", 32'(eng_start), 32'(m_start_now));
            checkOutput("busy", 32'(busy), 32'(m_active));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_active != 0 && m_resp != 0));
            checkOutput("job_count", 32'(job_count), 32'(m_count));
            checkOutput("eng_sel", 32'(eng_sel), 32'(m_sel));
            if (m_active != 0 && m_resp != 0) begin
                checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
                checkOutput("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    // Directed scenarios.
    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_count", 32'(job_count), 32'd0);
        reset = 1'b0;

        // round-robin with all requesters active
        done_delay = 3;
        applyStimulus(4'b1111, 1'b1);
        waitStarts(8, 400, "rr_starts_wait");
        applyStimulus(4'b0000, 1'b1);
        waitIdle(200, "rr_idle_wait");
        for (int i = 0; i < 8; i++) checkOutput("rr_order", 32'(gq[i]), 32'(i % 4));
        checkOutput("rr_count", 32'(job_count), 32'd8);

        // single job, done 37 cycles after start
        gq.delete();
        done_delay = 37;
        applyStimulus(4'b0001, 1'b1);
        waitStarts(1, 50, "single_start_wait");
        applyStimulus(4'b0000, 1'b1);
        waitIdle(200, "single_idle_wait");
        checkOutput("single_gnt_id", 32'(gq[0]), 32'd0);
        checkOutput("single_latency", 32'(last_lat), 32'd38);
        checkOutput("single_rsp_id", 32'(last_id), 32'd0);
        checkOutput("single_rsp_err", 32'(last_err), 32'd0);
        checkOutput("single_count", 32'(job_count), 32'd9);

        // stale done held from the previous job for 1 and then 3 cycles after start
        for (int h = 0; h < 2; h++) begin
            gq.delete();
            done_delay = 10;
            stale_hold = (h == 0) ? 1 : 3;
            checkOutput("stale_pre_done", 32'(eng_done), 32'd1);
            applyStimulus(4'b0001, 1'b1);
            waitStarts(1, 50, "stale_start_wait");
            applyStimulus(4'b0000, 1'b1);
            waitIdle(200, "stale_idle_wait");
            checkOutput("stale_latency", 32'(last_lat), 32'd11);
            checkOutput("stale_count", 32'(job_count), 32'(10 + h));
        end
        stale_hold = 0;

        // timeout, then the next requester is served normally
        gq.delete();
        done_delay = 0;
        applyStimulus(4'b0110, 1'b1);
        waitStarts(1, 50, "to_start_wait");
        checkOutput("to_gnt_id", 32'(gq[0]), 32'd1);
        waitValid(200, "to_valid_wait");
        checkOutput("to_latency", 32'(last_lat), 32'd65);
        checkOutput("to_rsp_err", 32'(last_err), 32'd1);
        checkOutput("to_rsp_id", 32'(last_id), 32'd1);
        done_delay = 5;
        waitStarts(2, 50, "to_next_start_wait");
        applyStimulus(4'b0000, 1'b1);
        waitIdle(200, "to_idle_wait");
        checkOutput("to_next_gnt_id", 32'(gq[1]), 32'd2);
        checkOutput("to_count", 32'(job_count), 32'd13);

        // backpressure for 10 cycles during RESP
        gq.delete();
        done_delay = 5;
        applyStimulus(4'b1000, 1'b0);
        waitStarts(1, 50, "bp_start_wait");
        applyStimulus(4'b0000, 1'b0);
        waitValid(100, "bp_valid_wait");
        repeat (10) @(negedge clk);
        applyStimulus(4'b0000, 1'b1);
        waitIdle(50, "bp_idle_wait");
        checkOutput("bp_valid_cycles", 32'(vcount), 32'd11);
        checkOutput("bp_rsp_id", 32'(last_id), 32'd3);
        checkOutput("bp_no_new_start", 32'(gq.size()), 32'd1);
        checkOutput("bp_count", 32'(job_count), 32'd14);

        // asynchronous reset while waiting on the engine
        gq.delete();
        done_delay = 40;
        applyStimulus(4'b0100, 1'b1);
        waitStarts(1, 50, "rst_start_wait");
        applyStimulus(4'b0000, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("rst_pre_sel", 32'(eng_sel), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_sel", 32'(eng_sel), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_eng_start", 32'(eng_start), 32'd0);
        checkOutput("rst_count", 32'(job_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        gq.delete();
        done_delay = 4;
        applyStimulus(4'b0110, 1'b1);
        waitStarts(1, 50, "post_rst_start_wait");
        applyStimulus(4'b0000, 1'b1);
        waitIdle(100, "post_rst_idle_wait");
        checkOutput("post_rst_gnt_id", 32'(gq[0]), 32'd1);
        checkOutput("post_rst_count", 32'(job_count), 32'd1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
